nco_mix: RTL

//  Multi-channel numerically controlled oscillator with a built-in mixer.
//  - NUM_CH phase accumulators share one sine LUT, time-multiplexed one channel per cycle.
//  - On each next_sample request, every enabled channel advances, and the block emits the average of their sine codes.
//  - Sits between the control/register interface and the DAC/PWM sample consumer, replacing the single-tone nco.

---
 rtl/nco_mix.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/nco_mix.sv
`default_nettype none
// ============================================================================
//  Module      : nco_mix
//  Description : Multi-channel NCO with built-in mixer. NUM_CH phase
//                accumulators share one synchronous sine LUT, one channel per
//                cycle; each sample is the average of the enabled channels'
//                sine codes (divided by NUM_CH, not by the enabled count).
//  Revision    : 1.0 - initial release
// ============================================================================
module nco_mix #(
    parameter  int NUM_CH = 4,
    parameter  int ACC_W  = 24,
    parameter  int LUT_AW = 8,
    parameter  int CODE_W = 10,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fcw_wr_en,
    input  logic [CH_W-1:0]   fcw_wr_ch,
    input  logic [ACC_W-1:0]  fcw_wr_data,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              next_sample,
    input  logic              phase_clr,
    output logic              busy,
    output logic [CODE_W-1:0] code,
    output logic              code_valid
);

    localparam int                  c_lut_size = 1 << LUT_AW;
    localparam int                  c_mid      = 1 << (CODE_W - 1);
    localparam int                  c_sum_w    = CODE_W + CH_W + 1;
    localparam int                  c_shift    = $clog2(NUM_CH);
    localparam logic [CODE_W-1:0]   c_mid_code = CODE_W'(c_mid);
    localparam logic signed [c_sum_w-1:0] c_mid_s = c_sum_w'(c_mid);
    localparam logic [CH_W-1:0]     c_last_idx = CH_W'(NUM_CH - 1);
    localparam real                 c_pi       = 3.14159265358979323846;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STEP  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     r_state;
    logic [CH_W-1:0]            r_idx;
    logic [ACC_W-1:0]           r_acc [NUM_CH];
    logic [ACC_W-1:0]           r_fcw [NUM_CH];
    logic [CODE_W-1:0]          r_lut;
    logic                       r_lut_en;
    logic signed [c_sum_w-1:0]  r_sum;
    logic [CODE_W-1:0]          r_code;
    logic                       r_busy;
    logic                       r_valid;

    logic [CODE_W-1:0]          w_lut [c_lut_size];
    logic [ACC_W-1:0]           w_cur_acc;
    logic [ACC_W-1:0]           w_cur_fcw;
    logic                       w_cur_en;
    logic [ACC_W-1:0]           w_next_acc;
    logic [LUT_AW-1:0]          w_addr;
    logic signed [c_sum_w-1:0]  w_term;
    logic signed [c_sum_w-1:0]  w_avg;

    // Sine table folded to constants at elaboration: MID + floor((MID-1)*sin)
    for (genvar gi = 0; gi < c_lut_size; gi++) begin : g_lut
        localparam real c_ang = 2.0 * c_pi * real'(gi) / real'(c_lut_size);
        localparam int  c_val = c_mid + int'($floor(real'(c_mid - 1) * $sin(c_ang)));
        assign w_lut[gi] = CODE_W'(c_val);
    end

    // Select the channel currently being stepped and form its next phase
    always_comb begin
        w_cur_acc = '0;
        w_cur_fcw = '0;
        w_cur_en  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_idx == CH_W'(i)) begin
                w_cur_acc = r_acc[i];
                w_cur_fcw = r_fcw[i];
                w_cur_en  = ch_en[i];
            end
        end
        w_next_acc = w_cur_acc + w_cur_fcw;
        w_addr     = w_next_acc[ACC_W-1 -: LUT_AW];
        w_term     = r_lut_en ? ($signed({{(c_sum_w-CODE_W){1'b0}}, r_lut}) - c_mid_s) : '0;
        w_avg      = r_sum >>> c_shift;
    end

    // Frequency control words; out-of-range channel indices match nothing
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) r_fcw[i] <= '0;
        end else if (fcw_wr_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (fcw_wr_ch == CH_W'(i)) r_fcw[i] <= fcw_wr_data;
            end
        end
    end

    // Phase accumulators: cleared by phase_clr, stepped only in their STEP slot
    always_ff @(posedge clk) begin
        if (rst || phase_clr) begin
            for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
        end else if (r_state == S_STEP) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_idx == CH_W'(i) && ch_en[i]) r_acc[i] <= w_next_acc;
            end
        end
    end

    // Sweep sequencer: LUT read one slot behind the step, sum collected a slot later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_lut    <= '0;
            r_lut_en <= 1'b0;
            r_sum    <= '0;
            r_code   <= c_mid_code;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_lut   <= w_lut[w_addr];
            if (phase_clr) begin
                r_state  <= S_IDLE;
                r_idx    <= '0;
                r_lut_en <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (next_sample) begin
                            r_state  <= S_STEP;
                            r_idx    <= '0;
                            r_sum    <= '0;
                            r_lut_en <= 1'b0;
                            r_busy   <= 1'b1;
                        end
                    end
                    S_STEP: begin
                        r_sum    <= r_sum + w_term;
                        r_lut_en <= w_cur_en;
                        if (r_idx == c_last_idx) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_idx <= r_idx + CH_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        r_sum    <= r_sum + w_term;
                        r_lut_en <= 1'b0;
                        r_state  <= S_DONE;
                    end
                    default: begin
                        r_code  <= c_mid_code + w_avg[CODE_W-1:0];
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_idx   <= '0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy       = r_busy;
    assign code       = r_code;
    assign code_valid = r_valid;

endmodule
`default_nettype wire
